fb_pixel_writer: RTL

- Consumer end of the rasterizer pixel stream: accepts the 28-bit {x, y, color} pixels the rasterizer emits with a bare valid, and writes them into a framebuffer BRAM port.
- Buffers pixels in a small FIFO because the rasterizer has no ready/backpressure.
- Provides a framebuffer clear sweep and a frame-complete pulse for the display/swap logic.

---
 rtl/fb_pixel_writer_if.sv | 27 ++
 rtl/fb_pixel_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer_if.sv
// Pixel stream in and framebuffer write port out for fb_pixel_writer.
// Master drives the stream; slave (the writer) drives the BRAM port.
interface fb_pixel_writer_if #(
    parameter int ADDR_W = 17
);
    logic              valid_in;
    logic [27:0]       pixel_in;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;

    modport master (
        output valid_in,
        output pixel_in,
        input  fb_we,
        input  fb_addr,
        input  fb_data
    );

    modport slave (
        input  valid_in,
        input  pixel_in,
        output fb_we,
        output fb_addr,
        output fb_data
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Rasterizer pixel sink: FIFO-buffered framebuffer writer with
// clear sweep, frame-complete pulse and saturating drop counter.
module fb_pixel_writer #(
    parameter int          H_RES      = 320,
    parameter int          V_RES      = 240,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  BG_COLOR   = 8'h00,
    parameter int          ADDR_W     = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    fb_pixel_writer_if.slave   px,
    input  logic               clear_req,
    input  logic               frame_end,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        drop_count
);

    localparam int                AW     = $clog2(FIFO_DEPTH);
    localparam int                NPIX   = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] HRES_A = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [AW:0]       P_ONE  = (AW+1)'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    logic [27:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    logic              clear_pend_q, clear_pend_d;
    logic              frame_pend_q, frame_pend_d;
    logic [15:0]       drop_q, drop_d;

    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;

    logic [9:0]        in_x, in_y;
    logic [27:0]       head;
    logic [ADDR_W-1:0] head_addr;
    logic              empty, full, in_rng;
    logic              pop, push, drop;
    logic              drained, start_clr, fire_done;

    assign in_x   = px.pixel_in[27:18];
    assign in_y   = px.pixel_in[17:8];
    assign in_rng = (32'(in_x) < 32'(H_RES)) &&
                    (32'(in_y) < 32'(V_RES));

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Multiply lives in the write stage, straight off the FIFO head.
    assign head_addr = ADDR_W'(head[17:8]) * HRES_A +
                       ADDR_W'(head[27:18]);

    assign pop  = (state_q == IDLE) && !empty;
    assign push = px.valid_in && in_rng && (!full || pop);
    assign drop = px.valid_in && !push;

    assign drained   = empty && !fb_we_q;
    assign start_clr = (state_q == IDLE) && clear_pend_q && drained;
    assign fire_done = (state_q == IDLE) && !clear_pend_q &&
                       frame_pend_q && drained;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            clear_pend_q <= 1'b0;
            frame_pend_q <= 1'b0;
            drop_q       <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            clear_pend_q <= clear_pend_d;
            frame_pend_q <= frame_pend_d;
            drop_q       <= drop_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= px.pixel_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start_clr) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + A_ONE;
                if (clr_addr_q == LAST_A) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / datapath logic
    always_comb begin
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (state_q == CLEAR) begin
            fb_we_d   = 1'b1;
            fb_addr_d = clr_addr_q;
            fb_data_d = BG_COLOR;
        end else if (pop) begin
            fb_we_d   = 1'b1;
            fb_addr_d = head_addr;
            fb_data_d = head[7:0];
        end

        wr_ptr_d = push ? wr_ptr_q + P_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + P_ONE : rd_ptr_q;

        // A request arriving once the sweep is committed is dropped.
        clear_pend_d = clear_pend_q;
        if (start_clr) begin
            clear_pend_d = 1'b0;
        end else if (clear_req && state_q == IDLE) begin
            clear_pend_d = 1'b1;
        end

        frame_pend_d = fire_done ? 1'b0 : frame_pend_q;
        if (frame_end) begin
            frame_pend_d = 1'b1;
        end

        drop_d = drop_q;
        if (start_clr) begin
            drop_d = '0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    assign px.fb_we    = fb_we_q;
    assign px.fb_addr  = fb_addr_q;
    assign px.fb_data  = fb_data_q;
    assign frame_done  = fire_done;
    assign drop_count  = drop_q;
    assign busy        = (state_q != IDLE) || !empty || fb_we_q ||
                         clear_pend_q || frame_pend_q;

endmodule
